// File: rtl/motor_seq_pkg.sv
// rtl/motor_seq_pkg.sv - shared encodings, PWM period and direction-to-mask helper for the motor sequencer
package motor_seq_pkg;

    typedef enum logic [1:0] {
        DIR_STOP  = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BRAKE = 2'b01,
        ST_RAMP  = 2'b10,
        ST_RUN   = 2'b11
    } state_e;

    localparam int PWM_PERIOD = 255;

    // Bridge enables as {A_d, A_i, B_d, B_i}
    function automatic logic [3:0] dir_mask(input dir_e dir);
        logic [3:0] mask;
        case (dir)
            DIR_FWD:   mask = 4'b1010;
            DIR_RIGHT: mask = 4'b1001;
            DIR_LEFT:  mask = 4'b0110;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// rtl/motor_pwm_gen.sv - free-running 255-step PWM counter and duty compare
module motor_pwm_gen
    import motor_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_cur,
    output logic       pwm
);

    localparam logic [7:0] CNT_LAST = 8'(PWM_PERIOD - 1);

    logic [7:0] pwm_cnt_q;
    logic [7:0] pwm_cnt_d;

    // Counter wraps after CNT_LAST so duty 255 keeps the output high for the whole period
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (pwm_cnt_q == CNT_LAST) begin
            pwm_cnt_d = 8'd0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm = (pwm_cnt_q < duty_cur);

endmodule

// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - dead-time direction sequencer with duty ramp; soft start via MOTOR_SEQ_SOFT_START_EN
module motor_drive_sequencer
    import motor_seq_pkg::*;
#(
    parameter int DEAD_CYCLES = 1000,
    parameter int RAMP_DIV    = 2550,
    parameter int RAMP_STEP   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [7:0] cfg_duty,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    output logic [3:0] motor_out,
    output logic       busy
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [7:0]        STEP      = 8'(RAMP_STEP);

    state_e            state_q, state_d;
    dir_e              cur_dir_q, cur_dir_d;
    dir_e              next_dir_q, next_dir_d;
    logic [7:0]        duty_cur_q, duty_cur_d;
    logic [7:0]        duty_target_q, duty_target_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [3:0]        motor_out_q, motor_out_d;

    logic       pwm;
    logic       cmd_accept;
    logic       dir_change;
    dir_e       cmd_dir_e;
    logic [7:0] ramp_next;

    motor_pwm_gen u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .duty_cur (duty_cur_q),
        .pwm      (pwm)
    );

    assign cmd_dir_e  = dir_e'(cmd_dir);
    assign cmd_ready  = (state_q != ST_BRAKE);
    assign cmd_accept = cmd_valid & cmd_ready;
    assign dir_change = cmd_accept & (cmd_dir_e != cur_dir_q);
    assign busy       = (state_q == ST_BRAKE) || (state_q == ST_RAMP);
    assign motor_out  = motor_out_q;

    // One ramp step toward the target, clamped so it lands exactly on it
    always_comb begin
        ramp_next = duty_cur_q;
        if (duty_target_q > duty_cur_q) begin
            ramp_next = ((duty_target_q - duty_cur_q) > STEP) ? duty_cur_q + STEP : duty_target_q;
        end else if (duty_target_q < duty_cur_q) begin
            ramp_next = ((duty_cur_q - duty_target_q) > STEP) ? duty_cur_q - STEP : duty_target_q;
        end
    end

    // Sequencer next-state: dead-time on every direction change, then ramp or jump to target
    always_comb begin
        state_d       = state_q;
        cur_dir_d     = cur_dir_q;
        next_dir_d    = next_dir_q;
        duty_cur_d    = duty_cur_q;
        duty_target_d = cfg_we ? cfg_duty : duty_target_q;
        dead_cnt_d    = dead_cnt_q;
        ramp_cnt_d    = ramp_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept && (cmd_dir_e != DIR_STOP)) begin
                    next_dir_d = cmd_dir_e;
                    duty_cur_d = 8'd0;
                    dead_cnt_d = '0;
                    state_d    = ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    cur_dir_d  = next_dir_q;
                    ramp_cnt_d = '0;
                    if (next_dir_q == DIR_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
`ifdef MOTOR_SEQ_SOFT_START_EN
                        state_d = ST_RAMP;
`else
                        duty_cur_d = duty_target_q;
                        state_d    = ST_RUN;
`endif
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            ST_RAMP: begin
                if (dir_change) begin
                    next_dir_d = cmd_dir_e;
                    duty_cur_d = 8'd0;
                    dead_cnt_d = '0;
                    state_d    = ST_BRAKE;
                end else if (duty_cur_q == duty_target_q) begin
                    state_d = ST_RUN;
                end else if (ramp_cnt_q == RAMP_LAST) begin
                    ramp_cnt_d = '0;
                    duty_cur_d = ramp_next;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + 1'b1;
                end
            end
            default: begin
                if (dir_change) begin
                    next_dir_d = cmd_dir_e;
                    duty_cur_d = 8'd0;
                    dead_cnt_d = '0;
                    state_d    = ST_BRAKE;
                end else begin
`ifdef MOTOR_SEQ_SOFT_START_EN
                    if (duty_cur_q != duty_target_q) begin
                        ramp_cnt_d = '0;
                        state_d    = ST_RAMP;
                    end
`else
                    duty_cur_d = duty_target_q;
`endif
                end
            end
        endcase
    end

    // Output gating: only RAMP/RUN may drive the bridges
    always_comb begin
        motor_out_d = 4'b0000;
        if ((state_q == ST_RAMP) || (state_q == ST_RUN)) begin
            motor_out_d = dir_mask(cur_dir_q) & {4{pwm}};
        end
    end

    // State and output registers; reset drops the bridges immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_dir_q     <= DIR_STOP;
            next_dir_q    <= DIR_STOP;
            duty_cur_q    <= 8'd0;
            duty_target_q <= 8'd0;
            dead_cnt_q    <= '0;
            ramp_cnt_q    <= '0;
            motor_out_q   <= 4'b0000;
        end else begin
            state_q       <= state_d;
            cur_dir_q     <= cur_dir_d;
            next_dir_q    <= next_dir_d;
            duty_cur_q    <= duty_cur_d;
            duty_target_q <= duty_target_d;
            dead_cnt_q    <= dead_cnt_d;
            ramp_cnt_q    <= ramp_cnt_d;
            motor_out_q   <= motor_out_d;
        end
    end

endmodule
